// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte bus plus transmitter handshake.
// master = arbiter side, slave = requesters/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ack;
  logic [N_REQ-1:0]   grant;
  logic [7:0]         tx_din;
  logic               tx_en;
  logic               tx_rdy;
  logic               busy;
  logic               err;

  modport master (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  tx_rdy,
    output req_ack,
    output grant,
    output tx_din,
    output tx_en,
    output busy,
    output err
  );

  modport slave (
    output req_valid,
    output req_data,
    output req_last,
    output tx_rdy,
    input  req_ack,
    input  grant,
    input  tx_din,
    input  tx_en,
    input  busy,
    input  err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART byte transmitter.
// Ports: clk, rst (async low), bus (req_*, grant, tx_*, busy, err).
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BURST_MAX = 4,
  parameter int TO_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q;
  logic             sync2_q;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [7:0]       tx_din_q, tx_din_d;
  logic             tx_en_q, tx_en_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic [3:0]       burst_q, burst_d;
  logic [TW-1:0]    to_q, to_d;

  logic             rdy_s;
  logic             rel;
  logic             to_hit;
  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  logic [PW:0]      rr_sum;
  logic             cur_vld;
  logic [7:0]       cur_data;
  logic             cur_last;

  assign rdy_s    = sync2_q;
  assign cur_vld  = bus.req_valid[gidx_q];
  assign cur_last = bus.req_last[gidx_q];
  assign cur_data = bus.req_data[{gidx_q, 3'b000} +: 8];
  assign to_hit   = (to_q == TW'(TO_CYCLES - 1));

  // Search from ptr downwards in priority: the loop runs from the
  // farthest offset to the nearest so the nearest valid one wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      rr_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(N_REQ))
        rr_sum = rr_sum - (PW+1)'(N_REQ);
      if (bus.req_valid[rr_sum[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = rr_sum[PW-1:0];
      end
    end
  end

  // State register, tx_rdy synchroniser and datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      ptr_q    <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      tx_din_q <= '0;
      tx_en_q  <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      burst_q  <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= bus.tx_rdy;
      sync2_q  <= sync1_q;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      tx_din_q <= tx_din_d;
      tx_en_q  <= tx_en_d;
      err_q    <= err_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      to_q     <= to_d;
    end
  end

  // Next-state logic; rel marks every path that gives up the grant.
  always_comb begin
    state_d = state_q;
    rel     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld)
          state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!cur_vld) begin
          state_d = S_IDLE;
          rel     = 1'b1;
        end else if (rdy_s) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!rdy_s) begin
          state_d = S_DRAIN;
        end else if (to_hit) begin
          state_d = S_IDLE;
          rel     = 1'b1;
        end
      end
      S_DRAIN: begin
        if (rdy_s) begin
          if (last_q || burst_q == 4'(BURST_MAX)) begin
            state_d = S_IDLE;
            rel     = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    ack_d    = '0;
    tx_din_d = tx_din_q;
    tx_en_d  = tx_en_q;
    err_d    = 1'b0;
    last_d   = last_q;
    burst_d  = burst_q;
    to_d     = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gidx_d  = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
          burst_d = '0;
        end
      end
      S_LOAD: begin
        if (cur_vld && rdy_s) begin
          tx_din_d = cur_data;
          last_d   = cur_last;
          tx_en_d  = 1'b1;
          ack_d    = grant_q;
          burst_d  = burst_q + 4'd1;
          to_d     = '0;
        end
      end
      S_SEND: begin
        if (!rdy_s) begin
          tx_en_d = 1'b0;
        end else if (to_hit) begin
          // Byte is dropped; the requester was already acked.
          tx_en_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_DRAIN: begin
      end
      default: begin
        tx_en_d = 1'b0;
      end
    endcase
    if (rel) begin
      grant_d = '0;
      ptr_d   = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + PW'(1);
    end
  end

  assign bus.req_ack = ack_q;
  assign bus.grant   = grant_q;
  assign bus.tx_din  = tx_din_q;
  assign bus.tx_en   = tx_en_q;
  assign bus.err     = err_q;
  assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed + random bench with queue-based
// requesters, a transmitter model and a message-level arbitration model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int BM = 4;
  localparam int TO = 16;

  typedef struct {
    int         id;
    logic [7:0] b;
  } ev_t;

  logic clk;
  logic rst;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ(N),
    .BURST_MAX(BM),
    .TO_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] qd[N][$];
  logic       ql[N][$];
  ev_t        exp_q[$];
  int         log_q[$];
  int         want[$];
  int         nvec;
  int         nerr;
  int         mptr;
  int         txen_hi;
  int         err_n;
  bit         tx_auto;
  int         ph;
  int         tcnt;
  logic       prev_en;
  logic [7:0] prev_din;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (qd[i].size() > 0) begin
        v[i]       = 1'b1;
        d[8*i +: 8] = qd[i][0];
        l[i]       = ql[i][0];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
  endtask

  // Message-level model: rotate over non-empty queues from mptr,
  // each grant takes bytes until last, BM bytes, or queue empty.
  task automatic build_exp();
    logic [7:0] cd[N][$];
    logic       cl[N][$];
    int         g;
    int         n;
    logic       lst;
    ev_t        e;
    for (int i = 0; i < N; i++) begin
      cd[i] = qd[i];
      cl[i] = ql[i];
    end
    forever begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && cd[(mptr + k) % N].size() > 0)
          g = (mptr + k) % N;
      if (g < 0) break;
      n = 0;
      do begin
        e.id = g;
        e.b  = cd[g].pop_front();
        lst  = cl[g].pop_front();
        exp_q.push_back(e);
        n++;
      end while (!lst && n < BM && cd[g].size() > 0);
      mptr = (g + 1) % N;
    end
  endtask

  task automatic step();
    int  id;
    ev_t e;
    @(negedge clk);
    if (bus.req_ack != '0) begin
      id = 0;
      for (int i = 0; i < N; i++)
        if (bus.req_ack[i]) id = i;
      chk("ack_onehot", $countones(bus.req_ack), 1);
      chk("ack_grant", bus.grant, 1 << id);
      chk("ack_txen", bus.tx_en, 1);
      log_q.push_back(id);
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("ack_id", id, e.id);
        chk("ack_byte", bus.tx_din, e.b);
      end
      if (qd[id].size() > 0) begin
        void'(qd[id].pop_front());
        void'(ql[id].pop_front());
      end
    end
    if (bus.tx_en) begin
      txen_hi++;
      chk("txen_busy", bus.busy, 1);
      if (prev_en) chk("din_stable", bus.tx_din, prev_din);
    end
    if (bus.err) err_n++;
    prev_en  = bus.tx_en;
    prev_din = bus.tx_din;
    if (tx_auto) begin
      case (ph)
        0: if (bus.tx_en) begin ph = 1; tcnt = 0; end
        1: begin
          tcnt++;
          if (tcnt == 5) begin bus.tx_rdy = 1'b0; ph = 2; tcnt = 0; end
        end
        default: begin
          tcnt++;
          if (tcnt == 8) begin bus.tx_rdy = 1'b1; ph = 0; end
        end
      endcase
    end
    drive_reqs();
  endtask

  task automatic run_scn(input string tag, input bit to_exp);
    int cyc;
    log_q.delete();
    txen_hi = 0;
    err_n   = 0;
    build_exp();
    drive_reqs();
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(exp_q.size() == 0 && !bus.busy) && cyc < 3000);
    if (cyc >= 3000) chk({tag, "_bound"}, 0, 1);
    if (!to_exp) chk({tag, "_err"}, err_n, 0);
    chk({tag, "_grant_idle"}, bus.grant, 0);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, log_q.size(), want.size());
    for (int i = 0; i < want.size() && i < log_q.size(); i++)
      chk({tag, "_order"}, log_q[i], want[i]);
  endtask

  task automatic put(input int r, input logic [7:0] b, input logic l);
    qd[r].push_back(b);
    ql[r].push_back(l);
  endtask

  initial begin
    int c;
    nvec    = 0;
    nerr    = 0;
    mptr    = 0;
    tx_auto = 1'b1;
    ph      = 0;
    tcnt    = 0;
    prev_en = 1'b0;
    prev_din = '0;
    bus.tx_rdy = 1'b1;
    drive_reqs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_ack", bus.req_ack, 0);
    chk("rst_txen", bus.tx_en, 0);
    chk("rst_txdin", bus.tx_din, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b1;

    put(0, 8'hA5, 1'b1);
    run_scn("single", 1'b0);
    want = '{0};
    chk_log("single");

    for (int j = 0; j < 6; j++) put(1, 8'($urandom_range(0, 255)), 1'b0);
    put(2, 8'h3C, 1'b1);
    run_scn("burst", 1'b0);
    want = '{1, 1, 1, 1, 2, 1, 1};
    chk_log("burst");

    put(0, 8'h11, 1'b0);
    put(0, 8'h22, 1'b0);
    put(0, 8'h33, 1'b1);
    put(1, 8'h44, 1'b1);
    run_scn("early", 1'b0);
    want = '{0, 0, 0, 1};
    chk_log("early");

    put(0, 8'h55, 1'b1);
    put(1, 8'h66, 1'b1);
    run_scn("ptr2", 1'b0);
    want = '{0, 1};
    chk_log("ptr2");

    tx_auto = 1'b0;
    bus.tx_rdy = 1'b1;
    put(2, 8'h77, 1'b1);
    run_scn("tmo", 1'b1);
    chk("tmo_txen_cycles", txen_hi, TO);
    chk("tmo_err_pulses", err_n, 1);
    chk("tmo_busy", bus.busy, 0);
    tx_auto = 1'b1;
    ph = 0;

    put(2, 8'h88, 1'b1);
    put(3, 8'h99, 1'b1);
    run_scn("post_tmo", 1'b0);
    want = '{3, 2};
    chk_log("post_tmo");

    for (int j = 0; j < 3; j++) put(3, 8'hC0 + 8'(j), 1'b0);
    build_exp();
    drive_reqs();
    c = 0;
    do begin
      step();
      c++;
    end while (!bus.tx_en && c < 200);
    if (c >= 200) chk("rstmid_bound", 0, 1);
    rst = 1'b0;
    #1;
    chk("rstmid_txen", bus.tx_en, 0);
    chk("rstmid_grant", bus.grant, 0);
    chk("rstmid_ack", bus.req_ack, 0);
    chk("rstmid_busy", bus.busy, 0);
    for (int i = 0; i < N; i++) begin
      qd[i].delete();
      ql[i].delete();
    end
    exp_q.delete();
    mptr = 0;
    bus.tx_rdy = 1'b1;
    ph = 0;
    drive_reqs();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    put(0, 8'h01, 1'b1);
    put(0, 8'h02, 1'b1);
    put(1, 8'h03, 1'b1);
    put(2, 8'h04, 1'b1);
    put(3, 8'h05, 1'b1);
    run_scn("rr", 1'b0);
    want = '{0, 1, 2, 3, 0};
    chk_log("rr");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        int n;
        n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++)
          put(i, 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
      end
      run_scn("rand", 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
